// File: rtl/gpo_sevenseg_if.sv
// Bundle between the GPO register side and the seven-segment display driver.
// The master drives the value and enable; the driver returns the pin-level outputs.
interface gpo_sevenseg_if;
  logic       en;
  logic [7:0] gpo_in;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [1:0] an_n;

  modport master (
    output en,
    output gpo_in,
    input  seg_n,
    input  dp_n,
    input  an_n
  );

  modport slave (
    input  en,
    input  gpo_in,
    output seg_n,
    output dp_n,
    output an_n
  );
endinterface

// File: rtl/gpo_sevenseg.sv
// Two-digit common-anode hex display driver for the GPO register, with a guard
// interval at the start of every digit slot and frame-synchronous value latching.
module gpo_sevenseg #(
  parameter int DIV   = 50000,
  parameter int GUARD = 500,
  parameter int LZB   = 0
) (
  input logic            clk,
  input logic            rst_n,
  gpo_sevenseg_if.slave  bus
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {
    DIG_LO = 1'b0,
    DIG_HI = 1'b1
  } dig_t;

  logic [CW-1:0] cnt;
  dig_t          dig;
  logic [7:0]    shown;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          dp_q;

  logic          in_guard;
  logic          lzb_blank;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // With no guard interval the comparison would be constant, so it is elaborated away.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
      assign in_guard = (cnt < GUARD_C);
    end
  endgenerate

  assign lzb_blank = (LZB != 0) && (dig == DIG_HI) && (shown[7:4] == 4'h0);
  assign nibble    = (dig == DIG_HI) ? shown[7:4] : shown[3:0];

  // Scanner, frame latch and registered pin drivers; outputs reflect the pre-edge scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dig   <= DIG_LO;
      shown <= 8'h00;
      an_q  <= 2'b11;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else if (!bus.en) begin
      cnt   <= '0;
      dig   <= DIG_LO;
      shown <= bus.gpo_in;
      an_q  <= 2'b11;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      dp_q <= 1'b1;
      if (in_guard || lzb_blank) begin
        an_q  <= 2'b11;
        seg_q <= 7'h7F;
      end else begin
        an_q  <= (dig == DIG_HI) ? 2'b01 : 2'b10;
        seg_q <= hex_to_seg(nibble);
      end

      if (cnt == CNT_MAX) begin
        cnt <= '0;
        dig <= (dig == DIG_HI) ? DIG_LO : DIG_HI;
        if (dig == DIG_HI) begin
          shown <= bus.gpo_in;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;

endmodule

// File: tb/tb_gpo_sevenseg.sv
// Randomized bench for gpo_sevenseg: two instances (DIV=8/GUARD=2/LZB=0 and
// DIV=4/GUARD=1/LZB=1) compared every cycle against a slot/frame arithmetic model.
module tb_gpo_sevenseg;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gpo_sevenseg_if bus_a ();
  gpo_sevenseg_if bus_b ();

  gpo_sevenseg #(.DIV(8), .GUARD(2), .LZB(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  gpo_sevenseg #(.DIV(4), .GUARD(1), .LZB(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  int         div_p [2] = '{8, 4};
  int         grd_p [2] = '{2, 1};
  int         lzb_p [2] = '{0, 1};
  int         t_m   [2];
  logic [7:0] sh_m  [2];
  logic [1:0] exp_an  [2];
  logic [6:0] exp_seg [2];

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected pins after the coming edge, from the position within the frame (t = cycles since frame start).
  task automatic modelStep(input int k, input logic rst_v, input logic en_v, input logic [7:0] gpo_v);
    int slot, off, dg;
    logic [3:0] nib;
    exp_an[k]  = 2'b11;
    exp_seg[k] = 7'h7F;
    if (!rst_v) begin
      t_m[k]  = 0;
      sh_m[k] = 8'h00;
    end else if (!en_v) begin
      t_m[k]  = 0;
      sh_m[k] = gpo_v;
    end else begin
      slot = t_m[k] / div_p[k];
      off  = t_m[k] % div_p[k];
      dg   = slot % 2;
      nib  = (dg == 1) ? sh_m[k][7:4] : sh_m[k][3:0];
      if (!(off < grd_p[k] || (lzb_p[k] != 0 && dg == 1 && sh_m[k][7:4] == 4'h0))) begin
        exp_an[k]  = (dg == 1) ? 2'b01 : 2'b10;
        exp_seg[k] = hex_tab[nib];
      end
      if (t_m[k] == 2 * div_p[k] - 1) sh_m[k] = gpo_v;
      t_m[k] = (t_m[k] + 1) % (2 * div_p[k]);
    end
  endtask

  task automatic checkAll();
    checkOutput("a_an",      {6'b0, bus_a.an_n},  {6'b0, exp_an[0]});
    checkOutput("a_seg",     {1'b0, bus_a.seg_n}, {1'b0, exp_seg[0]});
    checkOutput("a_dp",      {7'b0, bus_a.dp_n},  8'h01);
    checkOutput("a_overlap", {7'b0, bus_a.an_n == 2'b00}, 8'h00);
    checkOutput("b_an",      {6'b0, bus_b.an_n},  {6'b0, exp_an[1]});
    checkOutput("b_seg",     {1'b0, bus_b.seg_n}, {1'b0, exp_seg[1]});
    checkOutput("b_dp",      {7'b0, bus_b.dp_n},  8'h01);
    checkOutput("b_overlap", {7'b0, bus_b.an_n == 2'b00}, 8'h00);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [7:0] gpo_v);
    rst_n        = rst_v;
    bus_a.en     = en_v;
    bus_b.en     = en_v;
    bus_a.gpo_in = gpo_v;
    bus_b.gpo_in = gpo_v;
    modelStep(0, rst_v, en_v, gpo_v);
    modelStep(1, rst_v, en_v, gpo_v);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Pull reset between edges and confirm the pins go dark before any clock arrives.
  task automatic asyncReset(input logic en_v, input logic [7:0] gpo_v);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("a_async_an",  {6'b0, bus_a.an_n},  8'h03);
    checkOutput("a_async_seg", {1'b0, bus_a.seg_n}, 8'h7F);
    checkOutput("b_async_an",  {6'b0, bus_b.an_n},  8'h03);
    checkOutput("b_async_seg", {1'b0, bus_b.seg_n}, 8'h7F);
    applyStimulus(1'b0, en_v, gpo_v);
  endtask

  initial begin
    logic [7:0] gpo_r;
    logic       en_r;

    rst_n        = 1'b0;
    bus_a.en     = 1'b1;
    bus_b.en     = 1'b1;
    bus_a.gpo_in = 8'hA5;
    bus_b.gpo_in = 8'hA5;

    repeat (4)  applyStimulus(1'b0, 1'b1, 8'hA5);
    repeat (24) applyStimulus(1'b1, 1'b1, 8'hA5);

    repeat (3)  applyStimulus(1'b1, 1'b0, 8'h3C);
    repeat (12) applyStimulus(1'b1, 1'b1, 8'h3C);
    repeat (40) applyStimulus(1'b1, 1'b1, 8'h7F);

    repeat (2)  applyStimulus(1'b1, 1'b0, 8'h05);
    repeat (40) applyStimulus(1'b1, 1'b1, 8'h05);

    repeat (5)  applyStimulus(1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b0, 8'h5A);
    repeat (20) applyStimulus(1'b1, 1'b1, 8'h5A);

    applyStimulus(1'b1, 1'b0, 8'h96);
    repeat (4)  applyStimulus(1'b1, 1'b1, 8'h96);
    asyncReset(1'b1, 8'h96);
    repeat (20) applyStimulus(1'b1, 1'b1, 8'h96);

    for (int v = 0; v < 16; v++) begin
      repeat (16) applyStimulus(1'b1, 1'b1, {v[3:0], v[3:0]});
    end

    gpo_r = 8'h00;
    en_r  = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) gpo_r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) gpo_r[7:4] = 4'h0;
      en_r = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 299) == 0) asyncReset(en_r, gpo_r);
      else applyStimulus(1'b1, en_r, gpo_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpo_sevenseg.md
# gpo_sevenseg

Display driver that sits directly downstream of the general-purpose output register. It consumes the 8-bit GPO value and shows it as two hexadecimal digits on a common-anode, time-multiplexed 2-digit seven-segment display. The block contains a refresh divider, a digit scanner with anti-ghosting guard time, and frame-synchronous latching of the input value so that a digit never changes in the middle of a frame.

## Interface
- DIV, 50000, clock cycles per digit slot; legal range ≥ 2.
- GUARD, 500, blank cycles at the start of each slot, all anodes off; legal range 0 ≤ GUARD < DIV.
- LZB, 0, leading-zero blank; when 1, the upper digit is dark if the upper nibble is 0.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  display enable.
- gpo_in  in  8  value taken from the GPO register output.
- seg_n  out  7  segments {g,f,e,d,c,b,a}; active low.
- dp_n  out  1  decimal point; active low.
- an_n  out  2  digit anodes; active low. Bit 0 drives the low nibble, bit 1 drives the high nibble.

## Operation
- State:
  - tick counter `cnt`, range 0..DIV-1
  - digit index `dig`, 0 or 1
  - frame-latched value `shown[7:0]`
  - registered outputs
- Counting (en=1):
  - cnt increments every cycle.
  - At cnt==DIV-1, cnt wraps to 0 and dig toggles.
- Frame latch: on the cycle where cnt==DIV-1 and dig==1, shown is loaded with gpo_in. Frames are always digit 0 followed by digit 1.
- Disabled (en=0):
  - cnt=0, dig=0.
  - shown is loaded with gpo_in every cycle.
  - an_n=2'b11, seg_n=7'h7F, dp_n=1.
- Scan states per slot:
  - GUARD (cnt < GUARD): an_n=2'b11, seg_n=7'h7F.
  - DRIVE (cnt ≥ GUARD): the anode for `dig` is low and the other is high; seg_n is the encoding of nibble shown[4*dig+3 : 4*dig].
- LZB=1 and shown[7:4]==0: the digit-1 DRIVE slot behaves like GUARD, with all anodes off.
- Hex encoding of seg_n, digits 0 to F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- dp_n = 1 at all times. The port exists for board-level compatibility.
- Reset (asynchronous, any state): cnt=0, dig=0, shown=8'h00, an_n=2'b11, seg_n=7'h7F, dp_n=1. Normal operation resumes on the first clock edge with rst_n=1.

## Timing
- Outputs are registered. an_n, seg_n and dp_n on cycle n+1 reflect cnt, dig, shown and en on cycle n, giving 1-cycle latency.
- Slot period: DIV cycles. Frame period: 2·DIV cycles. Digit on-time per slot: DIV−GUARD cycles.
- Both anodes are never low in the same cycle, including at slot boundaries. GUARD=0 is allowed; with it, the anode handover is a single-cycle switch.
- gpo_in change latency:
  - The new value is shown starting with the first digit-0 DRIVE cycle after the next frame-end latch.
  - Worst case is 2·DIV+GUARD+1 cycles.
  - Changes to gpo_in mid-frame never alter the current frame.
- en falling: outputs are dark on the next cycle, and counters are reset.
- en rising: the scan starts at cnt=0, dig=0, using the value latched on the last disabled cycle. The first lit anode appears GUARD+1 cycles after en rises.
- Reset asserted mid-slot: outputs are dark immediately (asynchronously), with no glitch to a lit state.

## Test plan
- Reset value, DIV=8, GUARD=2: hold rst_n=0 with gpo_in=8'hA5 and en=1.
  - Required: an_n=11, seg_n=7F, dp_n=1 throughout.
  - After release, an_n=10 with seg_n=1000000 ("0", shown=00) from cycle 3 to 8.
- Scan pattern, DIV=8, GUARD=2, en=0→1, gpo_in=8'h3C:
  - an_n sequence per frame is 11,11,10×6,11,11,01×6.
  - seg_n is 1000110 ("C") on digit 0 and 0110000 ("3") on digit 1.
  - The two anodes are never both low.
- Frame-synchronous update: change gpo_in 8'h3C→8'h7F midway through a digit-1 slot.
  - The digit-1 slot still shows "3".
  - The next frame shows "F" (0001110), then "7" (1111000).
- Leading-zero blank, LZB=1, gpo_in=8'h05: the digit-1 slot keeps an_n=11; digit 0 shows 0010010.
  - With LZB=0, digit 1 shows 1000000.
- Enable and reset mid-operation:
  - Deassert en during a DRIVE cycle: the next cycle has an_n=11 and cnt=0.
  - Assert rst_n=0 asynchronously between clock edges during DRIVE: an_n=11 and seg_n=7F before the next edge, and shown=00 afterwards.
- Full hex sweep, DIV=4, GUARD=1: step gpo_in through 8'h00, 8'h11 … 8'hFF, one value per frame-latch window.
  - Both digits match the encoding list for every nibble value.
